// File: rtl/acis_cfg_pkg.sv
// Shared widths and types for the ACIS per-PE configuration tables.
package acis_cfg_pkg;
    localparam int phit_size    = 512;
    localparam int sz_config    = 24;
    localparam int depth_RF     = 16;
    localparam int dwidth_RFadd = $clog2(depth_RF);

    typedef enum logic {BANK_CTRL = 1'b0, BANK_IMM = 1'b1} bank_e;

    typedef enum logic [1:0] {WR_IDLE, WR_LOAD, WR_COMMIT} wr_state_e;
endpackage

// File: rtl/cfg_ctx_ram.sv
// One-write one-read table holding NUM_CTX contexts of DEPTH words, registered read port.
module cfg_ctx_ram
    import acis_cfg_pkg::*;
#(
    parameter int W       = sz_config,
    parameter int DEPTH   = depth_RF,
    parameter int NUM_CTX = 2,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = $clog2(NUM_CTX)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [CW-1:0] wr_ctx,
    input  logic [AW-1:0] wr_add,
    input  logic [W-1:0]  wr_data,
    input  logic          re,
    input  logic [CW-1:0] rd_ctx,
    input  logic [AW-1:0] rd_add,
    output logic [W-1:0]  rd_data
);
    logic [W-1:0] mem [2**(CW+AW)];

    // Storage itself is never reset; only the read register is.
    always_ff @(posedge clk) begin
        if (we) mem[{wr_ctx, wr_add}] <= wr_data;
    end

    always_ff @(posedge clk) begin
        if (!rst_n)  rd_data <= '0;
        else if (re) rd_data <= mem[{rd_ctx, rd_add}];
    end
endmodule

// File: rtl/config_table_mc.sv
// Multi-context configuration table: host streams beats into the shadow context while
// the datapath reads the active one; a commit swaps them atomically.
module config_table_mc
    import acis_cfg_pkg::*;
#(
    parameter int PHIT    = phit_size,
    parameter int SZ_CFG  = sz_config,
    parameter int DEPTH   = depth_RF,
    parameter int NUM_CTX = 2,
    localparam int AW     = $clog2(DEPTH),
    localparam int CW     = $clog2(NUM_CTX)
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              s_valid,
    output logic              s_ready,
    input  logic [PHIT-1:0]   s_data,
    input  logic              s_bank,
    input  logic              s_first,
    input  logic [AW-1:0]     s_add,
    input  logic              s_last,
    input  logic              commit,
    output logic              commit_done,
    input  logic              rd_en,
    input  logic [AW-1:0]     rd_add,
    output logic              rd_valid,
    output logic [SZ_CFG-1:0] rd_data_ctrl,
    output logic [PHIT-1:0]   rd_data_imm,
    output logic              rd_entry_vld,
    output logic [CW-1:0]     active_ctx,
    output logic              err_ovf
);
    localparam logic [AW:0]   LAST_ADD = (AW+1)'(DEPTH - 1);
    localparam logic [CW-1:0] LAST_CTX = CW'(NUM_CTX - 1);

    wr_state_e                   state;
    logic [AW-1:0]               addr_cnt;
    logic                        drop;
    logic                        commit_pend;
    logic [NUM_CTX-1:0][DEPTH-1:0] entry_vld;
    logic [CW-1:0]               shadow_ctx;
    logic                        accept, in_pkt, wr_ok, ovf_hit, pend_now, wr_ctrl, wr_imm;
    logic [AW:0]                 next_addr;

    assign shadow_ctx = (active_ctx == LAST_CTX) ? '0 : active_ctx + CW'(1);

    // next_addr carries one extra bit so stepping past the last entry is detectable.
    always_comb begin
        accept    = s_valid && s_ready;
        in_pkt    = accept && (s_first || state == WR_LOAD);
        next_addr = s_first ? {1'b0, s_add} : {1'b0, addr_cnt} + (AW+1)'(1);
        wr_ok     = in_pkt && (s_first || !drop) && (next_addr <= LAST_ADD);
        ovf_hit   = in_pkt && !wr_ok;
        wr_ctrl   = wr_ok && (bank_e'(s_bank) == BANK_CTRL);
        wr_imm    = wr_ok && (bank_e'(s_bank) == BANK_IMM);
        pend_now  = commit || commit_pend;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state       <= WR_IDLE;
            s_ready     <= 1'b0;
            commit_pend <= 1'b0;
            commit_done <= 1'b0;
            active_ctx  <= '0;
            entry_vld   <= '0;
            addr_cnt    <= '0;
            drop        <= 1'b0;
            err_ovf     <= 1'b0;
        end else begin
            commit_done <= 1'b0;
            if (ovf_hit) err_ovf <= 1'b1;
            if (in_pkt)  drop <= !wr_ok;
            if (wr_ok)   addr_cnt <= next_addr[AW-1:0];
            if (wr_ctrl) entry_vld[shadow_ctx][next_addr[AW-1:0]] <= s_data[PHIT-1];
            case (state)
                WR_IDLE: begin
                    if (accept && s_first && !s_last) begin
                        state       <= WR_LOAD;
                        commit_pend <= pend_now;
                        s_ready     <= 1'b1;
                    end else if (pend_now) begin
                        state       <= WR_COMMIT;
                        commit_pend <= 1'b0;
                        s_ready     <= 1'b0;
                    end else begin
                        s_ready     <= 1'b1;
                    end
                end
                WR_LOAD: begin
                    // A commit seen mid-packet waits here until the last beat lands.
                    if (accept && s_last) begin
                        commit_pend <= 1'b0;
                        if (pend_now) begin
                            state   <= WR_COMMIT;
                            s_ready <= 1'b0;
                        end else begin
                            state   <= WR_IDLE;
                        end
                    end else begin
                        commit_pend <= pend_now;
                    end
                end
                WR_COMMIT: begin
                    state       <= WR_IDLE;
                    s_ready     <= 1'b1;
                    commit_pend <= 1'b0;
                    active_ctx  <= shadow_ctx;
                    commit_done <= 1'b1;
                    entry_vld[active_ctx] <= '0;
                end
                default: state <= WR_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rd_valid     <= 1'b0;
            rd_entry_vld <= 1'b0;
        end else begin
            rd_valid <= rd_en;
            if (rd_en) rd_entry_vld <= entry_vld[active_ctx][rd_add];
        end
    end

    cfg_ctx_ram #(.W(SZ_CFG), .DEPTH(DEPTH), .NUM_CTX(NUM_CTX)) u_ctrl_ram (
        .clk(clk), .rst_n(rst_n),
        .we(wr_ctrl), .wr_ctx(shadow_ctx), .wr_add(next_addr[AW-1:0]),
        .wr_data(s_data[PHIT-1 -: SZ_CFG]),
        .re(rd_en), .rd_ctx(active_ctx), .rd_add(rd_add), .rd_data(rd_data_ctrl)
    );

    cfg_ctx_ram #(.W(PHIT), .DEPTH(DEPTH), .NUM_CTX(NUM_CTX)) u_imm_ram (
        .clk(clk), .rst_n(rst_n),
        .we(wr_imm), .wr_ctx(shadow_ctx), .wr_add(next_addr[AW-1:0]),
        .wr_data(s_data),
        .re(rd_en), .rd_ctx(active_ctx), .rd_add(rd_add), .rd_data(rd_data_imm)
    );
endmodule

// File: tb/tb_config_table_mc.sv
// Self-checking bench for config_table_mc: directed corner cases plus random packets vs a model.
module tb_config_table_mc;
    import acis_cfg_pkg::*;

    logic         clk = 1'b0;
    logic         rst_n, s_valid, s_ready, s_bank, s_first, s_last, commit, commit_done;
    logic         rd_en, rd_valid, rd_entry_vld, err_ovf;
    logic [511:0] s_data, rd_data_imm;
    logic [3:0]   s_add, rd_add;
    logic [23:0]  rd_data_ctrl;
    logic [0:0]   active_ctx;

    int checks = 0;
    int errors = 0;
    int stall_cnt = 0;

    // Reference model: contents per context, which words are known, entry-valid flags.
    logic [23:0]  m_ctrl [2][16];
    logic [511:0] m_imm  [2][16];
    bit           m_kc   [2][16];
    bit           m_ki   [2][16];
    bit           m_vld  [2][16];
    int           m_active, m_next;
    bit           m_in_pkt, m_drop, m_err;

    typedef struct {
        logic [3:0]  addr;
        logic [23:0] ctrl;
        logic        vld;
    } rd_vec_t;
    rd_vec_t tbl [6];

    always #5 clk = ~clk;

    config_table_mc dut (
        .clk(clk), .rst_n(rst_n),
        .s_valid(s_valid), .s_ready(s_ready), .s_data(s_data), .s_bank(s_bank),
        .s_first(s_first), .s_add(s_add), .s_last(s_last),
        .commit(commit), .commit_done(commit_done),
        .rd_en(rd_en), .rd_add(rd_add), .rd_valid(rd_valid),
        .rd_data_ctrl(rd_data_ctrl), .rd_data_imm(rd_data_imm), .rd_entry_vld(rd_entry_vld),
        .active_ctx(active_ctx), .err_ovf(err_ovf)
    );

    task automatic checkOutput(input string name, input logic [511:0] act, input logic [511:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    function automatic logic [511:0] rand_beat(input logic [23:0] top);
        logic [511:0] r;
        for (int k = 0; k < 16; k++) r[k*32 +: 32] = $urandom;
        r[511 -: 24] = top;
        return r;
    endfunction

    task automatic model_beat(input logic bank, input logic first, input logic last,
                              input logic [3:0] add, input logic [511:0] data);
        int a;
        int sh;
        sh = (m_active + 1) % 2;
        if (first) begin
            a = int'(add);
            m_drop = 0;
        end else if (!m_in_pkt) begin
            return;
        end else begin
            a = m_next;
        end
        m_in_pkt = !last;
        if (m_drop || a > 15) begin
            m_drop = 1;
            m_err  = 1;
        end else begin
            if (bank == 1'b0) begin
                m_ctrl[sh][a] = data[511 -: 24];
                m_kc[sh][a]   = 1;
                m_vld[sh][a]  = data[511];
            end else begin
                m_imm[sh][a] = data;
                m_ki[sh][a]  = 1;
            end
            m_next = a + 1;
        end
    endtask

    task automatic model_swap();
        int old;
        old = m_active;
        m_active = (m_active + 1) % 2;
        for (int a = 0; a < 16; a++) m_vld[old][a] = 0;
    endtask

    // Drives one beat from a negedge, waits (bounded) for acceptance, returns at a negedge.
    task automatic applyStimulus(input logic bank, input logic first, input logic last,
                                 input logic [3:0] add, input logic [511:0] data, input logic cmt);
        bit accepted;
        accepted = 0;
        s_valid = 1; s_bank = bank; s_first = first; s_last = last; s_add = add; s_data = data;
        commit = cmt;
        for (int i = 0; i < 20 && !accepted; i++) begin
            accepted = s_ready;
            @(negedge clk);
            commit = 0;
            if (!accepted) stall_cnt++;
        end
        s_valid = 0;
        if (!accepted) begin
            checks++;
            errors++;
            $display("[TB] FAIL beat_accept_timeout: got s_ready=0 for 20 cycles, expected 1");
        end else begin
            model_beat(bank, first, last, add, data);
        end
    endtask

    task automatic pulse_commit();
        commit = 1;
        @(negedge clk);
        commit = 0;
    endtask

    task automatic wait_commit_done(input string name);
        bit seen;
        seen = 0;
        for (int i = 0; i < 10 && !seen; i++) begin
            @(negedge clk);
            seen = commit_done;
        end
        checkOutput({name, "_commit_done"}, seen, 1);
        if (seen) begin
            model_swap();
            checkOutput({name, "_active_ctx"}, active_ctx, m_active);
            @(negedge clk);
            checkOutput({name, "_done_one_cycle"}, commit_done, 0);
        end
    endtask

    task automatic issue_read(input logic [3:0] addr);
        rd_en = 1;
        rd_add = addr;
        @(negedge clk);
        rd_en = 0;
    endtask

    task automatic read_check(input logic [3:0] addr, input string name);
        issue_read(addr);
        checkOutput({name, "_rd_valid"}, rd_valid, 1);
        checkOutput({name, "_entry_vld"}, rd_entry_vld, m_vld[m_active][addr]);
        if (m_kc[m_active][addr]) checkOutput({name, "_ctrl"}, rd_data_ctrl, m_ctrl[m_active][addr]);
        if (m_ki[m_active][addr]) checkOutput({name, "_imm"}, rd_data_imm, m_imm[m_active][addr]);
    endtask

    task automatic do_reset();
        rst_n = 0; s_valid = 0; commit = 0; rd_en = 0;
        @(negedge clk);
        @(negedge clk);
        checkOutput("rst_s_ready", s_ready, 0);
        checkOutput("rst_active_ctx", active_ctx, 0);
        checkOutput("rst_commit_done", commit_done, 0);
        checkOutput("rst_rd_valid", rd_valid, 0);
        checkOutput("rst_err_ovf", err_ovf, 0);
        checkOutput("rst_rd_entry_vld", rd_entry_vld, 0);
        checkOutput("rst_rd_data_ctrl", rd_data_ctrl, 0);
        checkOutput("rst_rd_data_imm", rd_data_imm, 0);
        rst_n = 1;
        m_active = 0; m_in_pkt = 0; m_drop = 0; m_err = 0;
        for (int c = 0; c < 2; c++) for (int a = 0; a < 16; a++) m_vld[c][a] = 0;
        @(negedge clk);
        checkOutput("post_rst_s_ready", s_ready, 1);
    endtask

    initial begin
        #300000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        logic [23:0] old_v, new_v;
        tbl[0] = '{addr: 4'd2, ctrl: 24'hC00010, vld: 1'b1};
        tbl[1] = '{addr: 4'd3, ctrl: 24'hC00011, vld: 1'b1};
        tbl[2] = '{addr: 4'd4, ctrl: 24'h400012, vld: 1'b0};
        tbl[3] = '{addr: 4'd5, ctrl: 24'hC00013, vld: 1'b1};
        tbl[4] = '{addr: 4'd6, ctrl: 24'h110006, vld: 1'b0};
        tbl[5] = '{addr: 4'd0, ctrl: 24'h110000, vld: 1'b0};
        for (int c = 0; c < 2; c++)
            for (int a = 0; a < 16; a++) begin
                m_kc[c][a] = 0; m_ki[c][a] = 0; m_vld[c][a] = 0;
            end
        rst_n = 0; s_valid = 0; s_bank = 0; s_first = 0; s_last = 0; s_add = 0;
        s_data = '0; commit = 0; rd_en = 0; rd_add = 0;

        // Preload both contexts' ctrl banks so every ctrl word has a known value.
        do_reset();
        for (int a = 0; a < 16; a++)
            applyStimulus(1'b0, a == 0, a == 15, 4'd0, rand_beat(24'h110000 + 24'(a)), 1'b0);
        pulse_commit();
        wait_commit_done("pre1");
        for (int a = 0; a < 16; a++)
            applyStimulus(1'b0, a == 0, a == 15, 4'd0, {24'h0, 488'h0}, 1'b0);
        pulse_commit();
        wait_commit_done("pre0");

        $display("[TB] test 1: stream ctrl packet into shadow");
        do_reset();
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd2, rand_beat(24'hC00010), 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, rand_beat(24'hC00011), 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, rand_beat(24'h400012), 1'b0);
        applyStimulus(1'b0, 1'b0, 1'b1, 4'd0, rand_beat(24'hC00013), 1'b0);
        issue_read(4'd2);
        checkOutput("t1_ctx0_ctrl", rd_data_ctrl, 24'h0);
        checkOutput("t1_ctx0_entry_vld", rd_entry_vld, 0);
        checkOutput("t1_active_ctx", active_ctx, 0);

        $display("[TB] test 2: commit and table reads");
        pulse_commit();
        wait_commit_done("t2");
        checkOutput("t2_active_is_1", active_ctx, 1);
        for (int i = 0; i < 6; i++) begin
            issue_read(tbl[i].addr);
            checkOutput($sformatf("t2_tbl%0d_rd_valid", i), rd_valid, 1);
            checkOutput($sformatf("t2_tbl%0d_ctrl", i), rd_data_ctrl, tbl[i].ctrl);
            checkOutput($sformatf("t2_tbl%0d_entry_vld", i), rd_entry_vld, tbl[i].vld);
        end
        @(negedge clk);
        checkOutput("t2_rd_valid_drops", rd_valid, 0);
        checkOutput("t2_rd_data_holds", rd_data_ctrl, 24'h110000);

        $display("[TB] test 3: commit deferred inside imm packet");
        stall_cnt = 0;
        for (int b = 0; b < 5; b++) begin
            applyStimulus(1'b1, b == 0, b == 4, 4'd8, rand_beat(24'(32'h00A000 + b)), b == 1);
            if (b >= 1) checkOutput($sformatf("t3_no_early_done_b%0d", b), commit_done, 0);
        end
        checkOutput("t3_no_stall", stall_cnt, 0);
        checkOutput("t3_ready_low_in_commit", s_ready, 0);
        wait_commit_done("t3");
        for (int a = 8; a < 13; a++) read_check(4'(a), $sformatf("t3_a%0d", a));

        $display("[TB] test 4: address overflow");
        checkOutput("t4_err_before", err_ovf, 0);
        for (int b = 0; b < 4; b++)
            applyStimulus(1'b0, b == 0, b == 3, 4'd14, rand_beat(24'h800300 + 24'(b)), 1'b0);
        checkOutput("t4_err_ovf", err_ovf, 1);
        pulse_commit();
        wait_commit_done("t4");
        for (int a = 13; a < 16; a++) read_check(4'(a), $sformatf("t4_a%0d", a));
        checkOutput("t4_addr15_const", rd_data_ctrl, 24'h800301);

        $display("[TB] test 5: read held across swap edge");
        applyStimulus(1'b0, 1'b1, 1'b1, 4'd0, rand_beat(24'hABCDEF), 1'b0);
        checkOutput("t5_err_sticky", err_ovf, 1);
        old_v = m_ctrl[m_active][0];
        new_v = m_ctrl[(m_active + 1) % 2][0];
        rd_en = 1; rd_add = 4'd0; commit = 1;
        @(negedge clk);
        commit = 0;
        checkOutput("t5_before_swap", rd_data_ctrl, old_v);
        @(negedge clk);
        checkOutput("t5_swap_edge_old", rd_data_ctrl, old_v);
        checkOutput("t5_swap_done", commit_done, 1);
        model_swap();
        checkOutput("t5_active", active_ctx, m_active);
        @(negedge clk);
        checkOutput("t5_after_new", rd_data_ctrl, new_v);
        checkOutput("t5_entry_vld", rd_entry_vld, m_vld[m_active][0]);
        checkOutput("t5_no_x", {$isunknown(rd_data_ctrl), $isunknown(rd_data_imm),
                                $isunknown(rd_valid), $isunknown(rd_entry_vld)}, 0);
        rd_en = 0;
        @(negedge clk);

        $display("[TB] test 6: reset mid-packet with pending commit");
        applyStimulus(1'b0, 1'b1, 1'b0, 4'd3, rand_beat(24'h812345), 1'b1);
        applyStimulus(1'b0, 1'b0, 1'b0, 4'd0, rand_beat(24'h812346), 1'b0);
        do_reset();
        for (int i = 0; i < 4; i++) begin
            checkOutput($sformatf("t6_no_done_%0d", i), commit_done, 0);
            checkOutput($sformatf("t6_active_%0d", i), active_ctx, 0);
            @(negedge clk);
        end
        for (int a = 0; a < 16; a++) begin
            issue_read(4'(a));
            checkOutput($sformatf("t6_entry_vld_a%0d", a), rd_entry_vld, 0);
        end
        for (int b = 0; b < 3; b++)
            applyStimulus(1'b1, b == 0, b == 2, 4'd4, rand_beat(24'(32'h00B000 + b)), b == 0);
        wait_commit_done("t6");
        for (int a = 4; a < 7; a++) read_check(4'(a), $sformatf("t6_a%0d", a));

        $display("[TB] test 7: random packets");
        for (int it = 0; it < 15; it++) begin
            logic       bank;
            logic [3:0] add;
            int         len, cpos;
            bank = 1'($urandom_range(0, 1));
            add  = 4'($urandom_range(0, 15));
            len  = $urandom_range(1, 5);
            cpos = $urandom_range(0, len);
            if ($urandom_range(0, 3) == 0)
                applyStimulus(bank, 1'b0, 1'b0, add, rand_beat(24'($urandom)), 1'b0);
            for (int b = 0; b < len; b++)
                applyStimulus(bank, b == 0, b == len - 1, add, rand_beat(24'($urandom)), b == cpos);
            checkOutput($sformatf("r%0d_err_ovf", it), err_ovf, m_err);
            if (cpos < len) wait_commit_done($sformatf("r%0d", it));
            for (int k = 0; k < 3; k++)
                read_check(4'($urandom_range(0, 15)), $sformatf("r%0d_rd%0d", it, k));
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
